// File: rtl/neuro_op_sequencer.sv
// Sequences one neuron op: walks index/weight caches, gathers layer values, drives the MAC term by term, then optionally activates and writes the sum.
// Latency: 5 cycles per term with a zero-wait MAC, plus one WRITE cycle (plus 1 + activation latency when enabled).
// Backpressure: the ISSUE state holds its operands stable while mac_ready is low; WAIT and ACT hold until mac_done / act_done.
module neuro_op_sequencer #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          start_op,
    output logic          ready_next_op,
    input  logic [AW-1:0] cfg_offset,
    input  logic [AW-1:0] cfg_dest,
    input  logic [15:0]   cfg_num_ops,
    input  logic          cfg_act_en,

    output logic [AW-1:0] idx_rd_addr,
    input  logic [DW-1:0] idx_rd_data,
    output logic [AW-1:0] w_rd_addr,
    input  logic [DW-1:0] w_rd_data,
    output logic [AW-1:0] val_rd_addr,
    input  logic [DW-1:0] val_rd_data,

    output logic          mac_valid,
    output logic          mac_first,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    input  logic          mac_ready,
    input  logic          mac_done,
    input  logic [DW-1:0] mac_result,

    output logic          act_valid,
    output logic [DW-1:0] act_in,
    input  logic          act_done,
    input  logic [DW-1:0] act_out,

    output logic          out_we,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_GATHER,
        S_OPERAND,
        S_ISSUE,
        S_WAIT,
        S_ACT,
        S_WRITE
    } state_t;

    // Control and datapath state
    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          first_q, first_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] w_q, w_d;
    logic [DW-1:0] a_q, a_d;
    logic [AW-1:0] dest_q, dest_d;
    logic          act_en_q, act_en_d;

    // Registered outputs, computed from the next state so they line up with it
    logic          ready_next_op_q, ready_next_op_d;
    logic [AW-1:0] idx_rd_addr_q, idx_rd_addr_d;
    logic [AW-1:0] w_rd_addr_q, w_rd_addr_d;
    logic          mac_valid_q, mac_valid_d;
    logic          mac_first_q, mac_first_d;
    logic [DW-1:0] mac_a_q, mac_a_d;
    logic [DW-1:0] mac_b_q, mac_b_d;
    logic          act_valid_q, act_valid_d;
    logic [DW-1:0] act_in_q, act_in_d;
    logic          out_we_q, out_we_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;

    // Next-state and datapath update; cfg is captured only on the accept cycle
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        acc_d    = acc_q;
        w_d      = w_q;
        a_d      = a_q;
        dest_d   = dest_q;
        act_en_d = act_en_q;

        case (state_q)
            S_IDLE: begin
                if (start_op) begin
                    ptr_d    = cfg_offset;
                    cnt_d    = cfg_num_ops;
                    first_d  = 1'b1;
                    dest_d   = cfg_dest;
                    act_en_d = cfg_act_en;
                    if (cfg_num_ops == 16'd0) begin
                        acc_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                state_d = S_GATHER;
            end
            S_GATHER: begin
                w_d     = w_rd_data;
                state_d = S_OPERAND;
            end
            S_OPERAND: begin
                a_d     = val_rd_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mac_ready) begin
                    first_d = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mac_done) begin
                    acc_d = mac_result;
                    ptr_d = ptr_q + AW'(1);
                    cnt_d = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = act_en_q ? S_ACT : S_WRITE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_ACT: begin
                if (act_done) begin
                    acc_d   = act_out;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state; inactive outputs are held at zero
    always_comb begin
        ready_next_op_d = (state_d == S_IDLE);
        idx_rd_addr_d   = (state_d == S_FETCH) ? ptr_d : '0;
        w_rd_addr_d     = (state_d == S_FETCH) ? ptr_d : '0;
        mac_valid_d     = (state_d == S_ISSUE);
        mac_first_d     = (state_d == S_ISSUE) && first_d;
        mac_a_d         = (state_d == S_ISSUE) ? a_d : '0;
        mac_b_d         = (state_d == S_ISSUE) ? w_d : '0;
        act_valid_d     = (state_d == S_ACT);
        act_in_d        = (state_d == S_ACT) ? acc_d : '0;
        out_we_d        = (state_d == S_WRITE);
        out_addr_d      = (state_d == S_WRITE) ? dest_d : '0;
        out_data_d      = (state_d == S_WRITE) ? acc_d : '0;
    end

    // State and output registers; reset aborts any op and re-arms the MAC clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            ptr_q           <= '0;
            cnt_q           <= '0;
            first_q         <= 1'b1;
            acc_q           <= '0;
            w_q             <= '0;
            a_q             <= '0;
            dest_q          <= '0;
            act_en_q        <= 1'b0;
            ready_next_op_q <= 1'b1;
            idx_rd_addr_q   <= '0;
            w_rd_addr_q     <= '0;
            mac_valid_q     <= 1'b0;
            mac_first_q     <= 1'b0;
            mac_a_q         <= '0;
            mac_b_q         <= '0;
            act_valid_q     <= 1'b0;
            act_in_q        <= '0;
            out_we_q        <= 1'b0;
            out_addr_q      <= '0;
            out_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            first_q         <= first_d;
            acc_q           <= acc_d;
            w_q             <= w_d;
            a_q             <= a_d;
            dest_q          <= dest_d;
            act_en_q        <= act_en_d;
            ready_next_op_q <= ready_next_op_d;
            idx_rd_addr_q   <= idx_rd_addr_d;
            w_rd_addr_q     <= w_rd_addr_d;
            mac_valid_q     <= mac_valid_d;
            mac_first_q     <= mac_first_d;
            mac_a_q         <= mac_a_d;
            mac_b_q         <= mac_b_d;
            act_valid_q     <= act_valid_d;
            act_in_q        <= act_in_d;
            out_we_q        <= out_we_d;
            out_addr_q      <= out_addr_d;
            out_data_q      <= out_data_d;
        end
    end

    // The value address depends on index data that only arrives during GATHER,
    // so it is a direct decode rather than a registered output.
    assign val_rd_addr   = (state_q == S_GATHER) ? idx_rd_data : '0;

    assign ready_next_op = ready_next_op_q;
    assign idx_rd_addr   = idx_rd_addr_q;
    assign w_rd_addr     = w_rd_addr_q;
    assign mac_valid     = mac_valid_q;
    assign mac_first     = mac_first_q;
    assign mac_a         = mac_a_q;
    assign mac_b         = mac_b_q;
    assign act_valid     = act_valid_q;
    assign act_in        = act_in_q;
    assign out_we        = out_we_q;
    assign out_addr      = out_addr_q;
    assign out_data      = out_data_q;

endmodule

// File: doc/neuro_op_sequencer.md
# neuro_op_sequencer

Sequencer for one NeuroSpider neuron operation. On `start_op` it walks the index and weight caches from `cfg_offset` for `cfg_num_ops` terms, gathers each operand from the layer-value cache, and feeds the half-float MAC one term at a time. It then optionally passes the sum through the activation unit and writes the result to `cfg_dest`. It sits between the memory-mapped register file (0x8000–0x8004) and the cache/MAC datapath, and it generates `ready_next_op`.

## Interface
- `AW`, 16: cache address width.
- `DW`, 16: data width (IEEE half float).
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start_op` in 1: operation request; accepted only while `ready_next_op`=1.
- `ready_next_op` out 1: high in IDLE only.
- `cfg_offset` in AW / `cfg_dest` in AW / `cfg_num_ops` in 16 / `cfg_act_en` in 1: register-file values, sampled on the accept cycle.
- `idx_rd_addr` out AW, `idx_rd_data` in DW: index cache; synchronous read, 1-cycle latency.
- `w_rd_addr` out AW, `w_rd_data` in DW: weight cache; 1-cycle latency.
- `val_rd_addr` out AW, `val_rd_data` in DW: layer-value cache; 1-cycle latency.
- `mac_valid` out 1, `mac_first` out 1, `mac_a` out DW, `mac_b` out DW, `mac_ready` in 1: MAC issue handshake. `mac_first`=1 makes the MAC discard its prior accumulator.
- `mac_done` in 1, `mac_result` in DW: running sum, valid while `mac_done`=1.
- `act_valid` out 1, `act_in` out DW, `act_done` in 1, `act_out` in DW: activation handshake.
- `out_we` out 1, `out_addr` out AW, `out_data` out DW: single-cycle result write.

## Operation
- States: IDLE, FETCH, GATHER, OPERAND, ISSUE, WAIT, ACT, WRITE.
- IDLE: `ready_next_op`=1.
  - On `start_op`, latch the cfg values: `ptr`=`cfg_offset`, `cnt`=`cfg_num_ops`, `first`=1.
  - If `cnt`=0, set `acc`=0x0000 and go to WRITE. Otherwise go to FETCH.
- FETCH: drive `idx_rd_addr` = `w_rd_addr` = `ptr`. Go to GATHER.
- GATHER: latch `w_reg`=`w_rd_data`; drive `val_rd_addr`=`idx_rd_data`. Go to OPERAND.
- OPERAND: latch `a_reg`=`val_rd_data`. Go to ISSUE.
- ISSUE:
  - Drive `mac_valid`=1, `mac_a`=`a_reg`, `mac_b`=`w_reg`, `mac_first`=`first`.
  - Hold all of these stable until `mac_ready`=1; then go to WAIT and clear `first`.
- WAIT: on `mac_done`:
  - `acc`=`mac_result`; `ptr`=`ptr`+1 (mod 2^AW); `cnt`=`cnt`−1.
  - If `cnt` was 1: go to ACT when `act_en`, else WRITE. Otherwise go to FETCH.
- ACT: `act_valid`=1, `act_in`=`acc`. Hold until `act_done`; then `acc`=`act_out` and go to WRITE.
- WRITE: `out_we`=1 for exactly one cycle, `out_addr`=latched dest, `out_data`=`acc`. Go to IDLE.
- Boundary conditions:
  - `start_op` outside IDLE is ignored, not queued.
  - cfg changes during an operation have no effect.
  - `mac_done` outside WAIT and `act_done` outside ACT are ignored.
  - `ptr` wraps 0xFFFF→0x0000.
  - `cnt` is 16-bit; 0xFFFF terms is legal.
- `reset` in any state:
  - Next state is IDLE.
  - No `out_we` is issued for the aborted operation.
  - `first` is set, so the next operation re-clears the MAC.

## Timing
- Reset values: `ready_next_op`=1. All other outputs 0: `mac_valid`, `mac_first`, `act_valid`, `out_we`, every address and data output.
- Cycle 0 is the cycle in which `start_op`=1 and `ready_next_op`=1. `ready_next_op` is 0 from cycle 1.
- Per term: 5 cycles minimum (FETCH, GATHER, OPERAND, ISSUE, WAIT), reached when `mac_ready`=1 in the ISSUE cycle and `mac_done`=1 in the next cycle.
- Each cycle of `mac_ready` low adds 1; each extra cycle of `mac_done` latency adds 1.
- N terms, no activation, zero-wait MAC: `out_we` in cycle 1+5N; `ready_next_op`=1 from cycle 2+5N.
  - With activation: add 1 + the `act_done` latency in cycles.
  - N=0: `out_we` in cycle 1 with 0x0000; ready from cycle 2.
- `start_op` in the cycle after WRITE is accepted. No dead cycle is inserted.

## Test plan
- Nominal: offset 0, dest 0, num_ops 2, idx {0,1}, val {0x3C00,0x4000}, w {0x3C00,0x4000}, act off, zero-wait fp16 MAC model -> `out_we` in cycle 11, addr 0x0000, data 0x4500 (5.0); `mac_first`=1 on term 0 only; ready at cycle 12.
- Zero ops: num_ops 0, dest 0x0007 -> `out_we` in cycle 1, addr 0x0007, data 0x0000; no `mac_valid` ever.
- Wrap and backpressure: offset 0xFFFF, num_ops 2, `mac_ready` low 3 cycles on term 1 -> `idx_rd_addr` 0xFFFF then 0x0000; operands stable while stalled; `out_we` in cycle 14.
- Activation: nominal setup, act_en 1, `act_done` 2 cycles after `act_valid` rises with `act_out`=0x3BF8 -> `act_in`=0x4500; `out_data`=0x3BF8 in cycle 14.
- Busy/config isolation: second `start_op` in cycle 3 and `cfg_dest` changed to 0x0005 in cycle 2 -> ignored; single write to addr 0x0000.
- Reset mid-op: `reset` asserted in the WAIT cycle of term 0 -> no `out_we`; `ready_next_op`=1 the cycle after reset; a following operation gives `mac_first`=1 and the correct 0x4500.
